// File: rtl/sprite_motion.sv
// Per-frame sprite physics: move, gravity, edge reflection for four sprites.
// Positions are committed to the outputs together once per frame.
module sprite_motion #(
  parameter int GRAV = 1,
  parameter int VMAX = 63
) (
  input  logic              clock_162,
  input  logic              rst_l,
  input  logic              frame_tick,
  input  logic              run,
  input  logic              load_valid,
  output logic              load_ready,
  input  logic [1:0]        load_idx,
  input  logic [10:0]       load_row,
  input  logic [11:0]       load_col,
  input  logic signed [7:0] load_vrow,
  input  logic signed [7:0] load_vcol,
  output logic [3:0][10:0]  sprite_row,
  output logic [3:0][11:0]  sprite_col,
  output logic              busy,
  output logic              overrun,
  output logic [15:0]       frame_count
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ROW,
    S_COL,
    S_COMMIT
  } state_t;

  localparam logic signed [8:0]  VMX = 9'(VMAX);
  localparam logic signed [8:0]  GV  = 9'(GRAV);
  localparam logic signed [12:0] LO  = 13'sd63;
  localparam logic signed [12:0] RHI = 13'sd1136;
  localparam logic signed [12:0] CHI = 13'sd1536;

  state_t                state;
  logic [1:0]            idx;
  logic [3:0][10:0]      row;
  logic [3:0][11:0]      col;
  logic signed [7:0]     vrow [4];
  logic signed [7:0]     vcol [4];

  logic signed [12:0]    raw_r, raw_c, nxt_r, nxt_c;
  logic signed [7:0]     v_r, v_c;
  logic signed [8:0]     vg;
  logic [10:0]           ld_row;
  logic [11:0]           ld_col;

  function automatic logic signed [7:0] clamp_v(input logic signed [8:0] v);
    if (v > VMX)
      return VMX[7:0];
    else if (v < -VMX)
      return 8'(-VMX);
    else
      return v[7:0];
  endfunction

  assign busy       = (state != S_IDLE);
  assign load_ready = ~busy;

  always_comb begin
    raw_r = $signed({2'b00, row[idx]}) + 13'(vrow[idx]);
    nxt_r = raw_r;
    v_r   = vrow[idx];
    if (raw_r < LO) begin
      nxt_r = 13'sd126 - raw_r;
      v_r   = -vrow[idx];
    end else if (raw_r > RHI) begin
      nxt_r = 13'sd2272 - raw_r;
      v_r   = -vrow[idx];
    end
    vg = 9'(v_r) + GV;

    raw_c = $signed({1'b0, col[idx]}) + 13'(vcol[idx]);
    nxt_c = raw_c;
    v_c   = vcol[idx];
    if (raw_c < LO) begin
      nxt_c = 13'sd126 - raw_c;
      v_c   = -vcol[idx];
    end else if (raw_c > CHI) begin
      nxt_c = 13'sd3072 - raw_c;
      v_c   = -vcol[idx];
    end

    ld_row = load_row;
    if (load_row < 11'd63)
      ld_row = 11'd63;
    else if (load_row > 11'd1136)
      ld_row = 11'd1136;

    ld_col = load_col;
    if (load_col < 12'd63)
      ld_col = 12'd63;
    else if (load_col > 12'd1536)
      ld_col = 12'd1536;
  end

  always_ff @(posedge clock_162 or negedge rst_l) begin
    if (!rst_l) begin
      state       <= S_IDLE;
      idx         <= 2'd0;
      overrun     <= 1'b0;
      frame_count <= 16'd0;
      for (int i = 0; i < 4; i++) begin
        row[i]        <= 11'd600;
        col[i]        <= 12'(200 + 400 * i);
        vrow[i]       <= 8'sd0;
        vcol[i]       <= 8'sd0;
        sprite_row[i] <= 11'd600;
        sprite_col[i] <= 12'(200 + 400 * i);
      end
    end else begin
      if (frame_tick && busy)
        overrun <= 1'b1;
      unique case (state)
        S_IDLE: begin
          if (load_valid) begin
            row[load_idx]  <= ld_row;
            col[load_idx]  <= ld_col;
            vrow[load_idx] <= clamp_v(9'(load_vrow));
            vcol[load_idx] <= clamp_v(9'(load_vcol));
          end
          if (frame_tick) begin
            idx   <= 2'd0;
            state <= run ? S_ROW : S_COMMIT;
          end
        end
        S_ROW: begin
          row[idx]  <= nxt_r[10:0];
          vrow[idx] <= clamp_v(vg);
          state     <= S_COL;
        end
        S_COL: begin
          col[idx]  <= nxt_c[11:0];
          vcol[idx] <= v_c;
          idx       <= idx + 2'd1;
          state     <= (idx == 2'd3) ? S_COMMIT : S_ROW;
        end
        S_COMMIT: begin
          sprite_row  <= row;
          sprite_col  <= col;
          frame_count <= frame_count + 16'd1;
          state       <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sprite_motion.sv
// Scoreboard bench for sprite_motion: driver queues expected commits,
// a monitor checks each commit as busy falls.
module tb_sprite_motion;

  logic              clock_162 = 1'b0;
  logic              rst_l = 1'b0;
  logic              frame_tick = 1'b0;
  logic              run = 1'b1;
  logic              load_valid = 1'b0;
  logic              load_ready;
  logic [1:0]        load_idx = 2'd0;
  logic [10:0]       load_row = 11'd0;
  logic [11:0]       load_col = 12'd0;
  logic signed [7:0] load_vrow = 8'sd0;
  logic signed [7:0] load_vcol = 8'sd0;
  logic [3:0][10:0]  sprite_row;
  logic [3:0][11:0]  sprite_col;
  logic              busy;
  logic              overrun;
  logic [15:0]       frame_count;

  sprite_motion #(.GRAV(1), .VMAX(63)) dut (
    .clock_162  (clock_162),
    .rst_l      (rst_l),
    .frame_tick (frame_tick),
    .run        (run),
    .load_valid (load_valid),
    .load_ready (load_ready),
    .load_idx   (load_idx),
    .load_row   (load_row),
    .load_col   (load_col),
    .load_vrow  (load_vrow),
    .load_vcol  (load_vcol),
    .sprite_row (sprite_row),
    .sprite_col (sprite_col),
    .busy       (busy),
    .overrun    (overrun),
    .frame_count(frame_count)
  );

  always #5 clock_162 = ~clock_162;

  typedef struct {
    int r[4];
    int c[4];
    int fc;
    int cyc;
    int blen;
  } exp_t;

  exp_t q[$];
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  bit   pb = 0;
  int   bc = 0;

  always @(posedge clock_162) cyc++;

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %0d want %0d", nm, act, exp);
    end
  endtask

  function automatic exp_t mk(input int r0, r1, r2, r3,
                              input int c0, c1, c2, c3,
                              input int fc);
    exp_t e;
    e.r[0] = r0; e.r[1] = r1; e.r[2] = r2; e.r[3] = r3;
    e.c[0] = c0; e.c[1] = c1; e.c[2] = c2; e.c[3] = c3;
    e.fc   = fc;
    e.cyc  = 0;
    e.blen = 0;
    return e;
  endfunction

  // monitor: a commit is the falling edge of busy
  always @(negedge clock_162) begin
    if (!rst_l) begin
      pb = 0;
      bc = 0;
    end else begin
      if (pb && !busy) begin
        if (q.size() == 0) begin
          chk("unexpected_commit", 1, 0);
        end else begin
          exp_t e;
          e = q.pop_front();
          for (int i = 0; i < 4; i++) begin
            chk($sformatf("row%0d", i), int'(sprite_row[i]), e.r[i]);
            chk($sformatf("col%0d", i), int'(sprite_col[i]), e.c[i]);
          end
          chk("frame_count", int'(frame_count), e.fc);
          chk("commit_cycle", cyc, e.cyc);
          chk("busy_len", bc, e.blen);
        end
        bc = 0;
      end
      if (busy)
        bc++;
      pb = busy;
    end
  end

  task automatic load(input int i, r, c, vr, vc);
    @(negedge clock_162);
    load_valid = 1'b1;
    load_idx   = 2'(i);
    load_row   = 11'(r);
    load_col   = 12'(c);
    load_vrow  = 8'(vr);
    load_vcol  = 8'(vc);
    @(negedge clock_162);
    load_valid = 1'b0;
  endtask

  task automatic tick(input bit r, input exp_t e, input bit push);
    @(negedge clock_162);
    run        = r;
    frame_tick = 1'b1;
    e.cyc      = cyc + 1 + (r ? 9 : 1);
    e.blen     = r ? 9 : 1;
    if (push)
      q.push_back(e);
    @(negedge clock_162);
    frame_tick = 1'b0;
  endtask

  task automatic drain();
    for (int k = 0; k < 40 && q.size() != 0; k++)
      @(negedge clock_162);
    @(negedge clock_162);
    chk("drain_timeout", q.size(), 0);
    q.delete();
  endtask

  initial begin
    exp_t e;
    #23;
    chk("rst_row0", int'(sprite_row[0]), 600);
    chk("rst_col3", int'(sprite_col[3]), 1400);
    chk("rst_busy", int'(busy), 0);
    chk("rst_ready", int'(load_ready), 1);
    rst_l = 1'b1;
    @(negedge clock_162);
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("rst_r%0d", i), int'(sprite_row[i]), 600);
      chk($sformatf("rst_c%0d", i), int'(sprite_col[i]), 200 + 400 * i);
    end
    chk("rst_fc", int'(frame_count), 0);
    chk("rst_ovr", int'(overrun), 0);

    // basic move; sprite 0 loaded in the same cycle as the tick
    load(0, 900, 900, 0, 0);
    load(1, 600, 600, 0, 0);
    load(2, 600, 1000, 0, 0);
    load(3, 600, 1400, 0, 0);
    chk("no_commit_on_load", int'(sprite_row[0]), 600);
    e = mk(105, 600, 600, 600, 90, 600, 1000, 1400, 1);
    @(negedge clock_162);
    load_valid = 1'b1;
    load_idx   = 2'd0;
    load_row   = 11'd100;
    load_col   = 12'd100;
    load_vrow  = 8'sd5;
    load_vcol  = -8'sd10;
    run        = 1'b1;
    frame_tick = 1'b1;
    e.cyc      = cyc + 10;
    e.blen     = 9;
    q.push_back(e);
    @(negedge clock_162);
    load_valid = 1'b0;
    frame_tick = 1'b0;
    drain();

    // bounce, gravity, saturation, load clamp
    load(0, 600, 70, 0, -10);
    load(1, 1130, 600, 10, 0);
    load(2, 500, 1000, 63, 0);
    load(3, 600, 2000, 0, -100);
    tick(1, mk(600, 1132, 563, 600, 66, 600, 1000, 1473, 2), 1);
    drain();
    tick(1, mk(601, 1123, 626, 601, 76, 600, 1000, 1410, 3), 1);
    drain();
    chk("no_overrun_yet", int'(overrun), 0);

    // overrun: second tick while busy is ignored
    load(0, 200, 300, 3, 4);
    load(1, 600, 600, 0, 0);
    load(2, 600, 1000, 0, 0);
    load(3, 600, 1400, 0, 0);
    tick(1, mk(203, 600, 600, 600, 304, 600, 1000, 1400, 4), 1);
    @(negedge clock_162);
    frame_tick = 1'b1;
    @(negedge clock_162);
    frame_tick = 1'b0;
    drain();
    chk("overrun_set", int'(overrun), 1);
    repeat (15) @(negedge clock_162);
    chk("overrun_sticky", int'(overrun), 1);
    chk("overrun_fc", int'(frame_count), 4);

    // commit-only frame, and a load refused while busy
    load(0, 300, 500, 7, 7);
    load(1, 400, 600, 0, 0);
    tick(0, mk(300, 400, 600, 600, 500, 600, 1000, 1400, 5), 1);
    chk("ready_low_busy", int'(load_ready), 0);
    load_valid = 1'b1;
    load_idx   = 2'd1;
    load_row   = 11'd900;
    load_col   = 12'd900;
    @(negedge clock_162);
    load_valid = 1'b0;
    drain();
    tick(0, mk(300, 400, 600, 600, 500, 600, 1000, 1400, 6), 1);
    drain();

    // reset in the middle of an update
    load(0, 100, 100, 5, -10);
    tick(1, mk(0, 0, 0, 0, 0, 0, 0, 0, 0), 0);
    repeat (3) @(posedge clock_162);
    #2 rst_l = 1'b0;
    #1;
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("mid_rst_r%0d", i), int'(sprite_row[i]), 600);
      chk($sformatf("mid_rst_c%0d", i), int'(sprite_col[i]), 200 + 400 * i);
    end
    chk("mid_rst_busy", int'(busy), 0);
    chk("mid_rst_fc", int'(frame_count), 0);
    chk("mid_rst_ovr", int'(overrun), 0);
    repeat (2) @(negedge clock_162);
    rst_l = 1'b1;
    tick(1, mk(600, 600, 600, 600, 200, 600, 1000, 1400, 1), 1);
    drain();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
